rsff_cmd_driver: RTL and testbench

Command-driven stimulus stage that sits directly upstream of a bank of technology RS flip-flops (posedge clock, active-high async reset, active-low async set). It accepts SET/CLEAR/LOAD/CHECK commands over a valid/ready handshake and turns each into correctly-sequenced `d`, `set_n` and `reset` drive for `WIDTH` flops. It reads the flop outputs back, compares them with a shadow copy and reports any mismatch. It is used in techmap sequential simulation benches, and in any netlist that needs controlled preset/clear of a register bank.

---
 rtl/rsff_cmd_driver_if.sv | 16 +
 rtl/rsff_cmd_driver.sv | 155 +++++++++++++++
 tb/tb_rsff_cmd_driver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rsff_cmd_driver_if.sv
// Command handshake bundle for rsff_cmd_driver: valid/ready plus opcode and data/mask.
`default_nettype none

interface rsff_cmd_driver_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

`default_nettype wire

// File: rtl/rsff_cmd_driver.sv
// Command-driven preset/clear/load driver for a bank of RS flops with readback compare.
// Optional readback compare enabled by defining RSFF_DRV_CHECK_EN.
`default_nettype none

module rsff_cmd_driver #(
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = 2
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n_i,
    rsff_cmd_driver_if.slave      cmd,
    output logic [WIDTH-1:0]      ff_d_o,
    output logic [WIDTH-1:0]      ff_set_n_o,
    output logic [WIDTH-1:0]      ff_reset_o,
    input  wire logic [WIDTH-1:0] ff_q_i,
    output logic                  done_o,
    output logic                  mismatch_o,
    output logic [7:0]            err_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] set_n_q;
    logic [WIDTH-1:0] reset_q;
    logic [3:0]       pulse_cnt_q;
    logic             ready_q;
    logic             done_q;
    logic             accept;

    assign accept = cmd.cmd_valid && ready_q;

`ifdef RSFF_DRV_CHECK_EN
    logic       mismatch_q;
    logic [7:0] err_count_q;
    logic [7:0] err_count_d;
    logic       cmp_fail;

    assign cmp_fail    = (ff_q_i != shadow_q);
    assign err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
    assign mismatch_o  = mismatch_q;
    assign err_count_o = err_count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mismatch_q  <= 1'b0;
            err_count_q <= 8'd0;
        end else if (state_q == ST_IDLE && accept) begin
            mismatch_q <= 1'b0;
        end else if (state_q == ST_CHECK) begin
            mismatch_q <= cmp_fail;
            if (cmp_fail) begin
                err_count_q <= err_count_d;
            end
        end
    end
`else
    logic unused_ff_q;
    assign unused_ff_q = ^ff_q_i;
    assign mismatch_o  = 1'b0;
    assign err_count_o = 8'd0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            set_n_q     <= '1;
            reset_q     <= '0;
            pulse_cnt_q <= 4'd0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        ready_q     <= 1'b0;
                        pulse_cnt_q <= PULSE_LAST;
                        case (cmd.cmd_op)
                            OP_LOAD: begin
                                shadow_q <= cmd.cmd_data;
                                state_q  <= ST_SETTLE;
                            end
                            OP_SET: begin
                                shadow_q <= shadow_q | cmd.cmd_data;
                                if (|cmd.cmd_data) begin
                                    set_n_q <= ~cmd.cmd_data;
                                    state_q <= ST_PULSE;
                                end else begin
                                    state_q <= ST_CHECK;
                                    done_q  <= 1'b1;
                                end
                            end
                            OP_CLEAR: begin
                                shadow_q <= shadow_q & ~cmd.cmd_data;
                                if (|cmd.cmd_data) begin
                                    reset_q <= cmd.cmd_data;
                                    state_q <= ST_PULSE;
                                end else begin
                                    state_q <= ST_CHECK;
                                    done_q  <= 1'b1;
                                end
                            end
                            default: begin
                                state_q <= ST_CHECK;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_PULSE: begin
                    // Release on the last pulse cycle so set and reset never overlap across commands.
                    if (pulse_cnt_q == 4'd0) begin
                        set_n_q <= '1;
                        reset_q <= '0;
                        state_q <= ST_SETTLE;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - 4'd1;
                    end
                end
                ST_SETTLE: begin
                    state_q <= ST_CHECK;
                    done_q  <= 1'b1;
                end
                ST_CHECK: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign ff_d_o        = shadow_q;
    assign ff_set_n_o    = set_n_q;
    assign ff_reset_o    = reset_q;
    assign done_o        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rsff_cmd_driver.sv
// Scoreboard bench for rsff_cmd_driver with a behavioural RS flop bank and stuck-at injection.
`timescale 1ns/1ps
`default_nettype none

module tb_rsff_cmd_driver;
    localparam int WIDTH        = 8;
    localparam int PULSE_CYCLES = 2;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_SET   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_CHECK = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rsff_cmd_driver_if #(.WIDTH(WIDTH)) cmd_if ();

    logic [WIDTH-1:0] ff_d, ff_set_n, ff_reset, ff_q, flop_q, stuck;
    logic             done, mismatch;
    logic [7:0]       err_count;

    rsff_cmd_driver #(.WIDTH(WIDTH), .PULSE_CYCLES(PULSE_CYCLES)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cmd         (cmd_if),
        .ff_d_o      (ff_d),
        .ff_set_n_o  (ff_set_n),
        .ff_reset_o  (ff_reset),
        .ff_q_i      (ff_q),
        .done_o      (done),
        .mismatch_o  (mismatch),
        .err_count_o (err_count)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_ff
        logic q;
        always @(posedge clk or posedge ff_reset[i] or negedge ff_set_n[i]) begin
            if (ff_reset[i])       q <= 1'b0;
            else if (!ff_set_n[i]) q <= 1'b1;
            else                   q <= ff_d[i];
        end
        assign flop_q[i] = q;
    end
    assign ff_q = flop_q | stuck;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] shadow;
        logic             mm;
        logic [7:0]       err;
        int               lat;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] sh_m  = '0;
    logic [7:0]       err_m = 8'd0;
    int               errors = 0;
    int               checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic collect();
        exp_t             h;
        exp_t             e;
        logic [WIDTH-1:0] exp_setn, exp_rst;
        bit               seen = 1'b0;
        h = sb[0];
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            exp_setn = '1;
            exp_rst  = '0;
            if (k <= PULSE_CYCLES && h.mask != '0) begin
                if (h.op == OP_SET)   exp_setn = ~h.mask;
                if (h.op == OP_CLEAR) exp_rst  = h.mask;
            end
            check_eq("set_n", 32'(ff_set_n), 32'(exp_setn));
            check_eq("reset", 32'(ff_reset), 32'(exp_rst));
            if (done === 1'b1) begin
                seen = 1'b1;
                e = sb.pop_front();
                check_eq("latency", k, e.lat);
                check_eq("ff_d", 32'(ff_d), 32'(e.shadow));
                check_eq("ff_q", 32'(ff_q), 32'(e.shadow | stuck));
            end else begin
                check_eq("ready_busy", 32'(cmd_if.cmd_ready), 32'd0);
            end
        end
        if (!seen) begin
            check_eq("done_timeout", 32'(done), 32'd1);
            sb.delete();
        end else begin
            @(negedge clk);
            check_eq("done_pulse", 32'(done), 32'd0);
            check_eq("ready_after", 32'(cmd_if.cmd_ready), 32'd1);
            check_eq("mismatch", 32'(mismatch), 32'(e.mm));
            check_eq("err_count", 32'(err_count), 32'(e.err));
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data);
        exp_t e;
        int   n = 0;
        while (cmd_if.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cmd_if.cmd_ready !== 1'b1) check_eq("ready_timeout", 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        case (op)
            OP_LOAD:  sh_m = data;
            OP_SET:   sh_m = sh_m | data;
            OP_CLEAR: sh_m = sh_m & ~data;
            default:  ;
        endcase
        e.op     = op;
        e.mask   = (op == OP_SET || op == OP_CLEAR) ? data : '0;
        e.shadow = sh_m;
`ifdef RSFF_DRV_CHECK_EN
        e.mm = ((sh_m | stuck) != sh_m);
        if (e.mm && err_m != 8'hFF) err_m = err_m + 8'd1;
`else
        e.mm = 1'b0;
`endif
        e.err = err_m;
        e.lat = (op == OP_LOAD) ? 2 : (e.mask != '0) ? PULSE_CYCLES + 2 : 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'($urandom);
        cmd_if.cmd_data  = WIDTH'($urandom);
        collect();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_data  = '0;
        stuck            = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_set_n", 32'(ff_set_n), 32'hFF);
        check_eq("rst_reset", 32'(ff_reset), 32'h00);
        check_eq("rst_ff_d", 32'(ff_d), 32'h00);
        check_eq("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mismatch", 32'(mismatch), 32'd0);
        check_eq("rst_err", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_release", 32'(cmd_if.cmd_ready), 32'd1);

        send(OP_LOAD, 8'hA5);
        send(OP_LOAD, 8'hA0);
        send(OP_SET, 8'h0F);

        stuck = 8'h01;
        for (int i = 0; i < 300; i++) send(OP_CLEAR, 8'h81);
        stuck = 8'h00;

        send(OP_SET, 8'h00);
        send(OP_CLEAR, 8'h00);
        send(OP_CHECK, 8'h55);
        send(OP_LOAD, 8'h3C);

        // Reset during the first pulse cycle of a SET.
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_SET;
        cmd_if.cmd_data  = 8'h0F;
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("midrst_pulse", 32'(ff_set_n), 32'hF0);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_set_n", 32'(ff_set_n), 32'hFF);
        check_eq("midrst_reset", 32'(ff_reset), 32'h00);
        check_eq("midrst_shadow", 32'(ff_d), 32'h00);
        sh_m  = '0;
        err_m = 8'd0;
        repeat (3) begin
            @(negedge clk);
            check_eq("midrst_done", 32'(done), 32'd0);
            check_eq("midrst_ready", 32'(cmd_if.cmd_ready), 32'd0);
            check_eq("midrst_err", 32'(err_count), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_release", 32'(cmd_if.cmd_ready), 32'd1);
        check_eq("midrst_no_done", 32'(done), 32'd0);

        send(OP_LOAD, 8'h5A);
        send(OP_CLEAR, 8'h18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
